// File: rtl/div_issue_queue_pkg.sv
// Shared uop/branch types for the divider path, plus the squash predicate
// used by both this queue and the divider itself.
package div_issue_queue_pkg;

  localparam int SQN_W = 7;
  localparam int TAG_W = 7;

  typedef logic [SQN_W-1:0] SqN;
  typedef logic [TAG_W-1:0] Tag;

  typedef enum logic [1:0] {
    DIV_DIV  = 2'd0,
    DIV_DIVU = 2'd1,
    DIV_REM  = 2'd2,
    DIV_REMU = 2'd3
  } DivOp;

  typedef struct packed {
    logic [31:0] srcA;
    logic [31:0] srcB;
    SqN          sqN;
    Tag          tagDst;
    DivOp        opcode;
    logic        valid;
  } EX_UOp;

  typedef struct packed {
    SqN   sqN;
    logic taken;
  } BranchProv;

  // A uop dies when it is strictly younger (wrapped distance) than a taken branch.
  function automatic logic IsSquashed(input SqN sqN, input BranchProv branch);
    SqN diff;
    diff = sqN - branch.sqN;
    return branch.taken && !diff[SQN_W-1] && (diff != '0);
  endfunction

endpackage

// File: rtl/div_issue_queue_if.sv
// Issue-stage / divider-side bundle of the divider issue queue.
interface div_issue_queue_if;
  import div_issue_queue_pkg::*;

  BranchProv IN_branch;
  EX_UOp     IN_uop;
  logic      OUT_full;
  logic      IN_divBusy;
  logic      OUT_en;
  EX_UOp     OUT_uop;

  modport master (
    output IN_branch,
    output IN_uop,
    output IN_divBusy,
    input  OUT_full,
    input  OUT_en,
    input  OUT_uop
  );

  modport slave (
    input  IN_branch,
    input  IN_uop,
    input  IN_divBusy,
    output OUT_full,
    output OUT_en,
    output OUT_uop
  );

endinterface

// File: rtl/div_issue_queue.sv
// Collapsing age-ordered queue feeding the iterative divider: squash, then pop
// the oldest entry, then append the incoming uop, all in one cycle.
module div_issue_queue
  import div_issue_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic              clk,
  input logic              rst,
  div_issue_queue_if.slave bus
);

  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int LOCK_W = 1;

  typedef logic [CNT_W-1:0] Cnt;

  EX_UOp             entries_q [DEPTH];
  EX_UOp             entries_d [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  valid_d;
  Cnt                count_q;
  Cnt                count_d;
  logic [LOCK_W-1:0] lockout_q;
  logic [LOCK_W-1:0] lockout_d;
  EX_UOp             outUop_q;
  EX_UOp             outUop_d;

  logic [DEPTH-1:0]  keep;
  Cnt                rank [DEPTH];
  Cnt                survivors;
  Cnt                tail;
  logic              full;
  logic              inSquashed;
  logic              pop;
  logic              enq;

  // rank[i] is the compacted position of entry i before any pop.
  always_comb begin
    survivors = '0;
    for (int i = 0; i < DEPTH; i++) begin
      keep[i]   = valid_q[i] && !IsSquashed(entries_q[i].sqN, bus.IN_branch);
      rank[i]   = survivors;
      survivors = survivors + Cnt'(keep[i]);
    end
  end

  assign full       = (count_q == Cnt'(DEPTH));
  assign inSquashed = IsSquashed(bus.IN_uop.sqN, bus.IN_branch);
  assign pop        = keep[0] && !bus.IN_divBusy && (lockout_q == '0);
  assign enq        = bus.IN_uop.valid && !full && !inSquashed;
  assign tail       = survivors - Cnt'(pop);
  assign count_d    = tail + Cnt'(enq);

  for (genvar gj = 0; gj < DEPTH; gj++) begin : g_slot
    EX_UOp slotUop;
    logic  slotVld;

    always_comb begin
      slotUop = entries_q[gj];
      slotVld = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        if (keep[i] && (rank[i] == Cnt'(gj) + Cnt'(pop))) begin
          slotUop = entries_q[i];
          slotVld = 1'b1;
        end
      end
      if (enq && (tail == Cnt'(gj))) begin
        slotUop = bus.IN_uop;
        slotVld = 1'b1;
      end
    end

    assign entries_d[gj] = slotUop;
    assign valid_d[gj]   = slotVld;
  end

  // The divider only raises busy a cycle after accepting, so block the next edge.
  always_comb begin
    if (pop) begin
      lockout_d = LOCK_W'(1);
    end else if (lockout_q != '0) begin
      lockout_d = lockout_q - LOCK_W'(1);
    end else begin
      lockout_d = '0;
    end
  end

  always_comb begin
    outUop_d       = entries_q[0];
    outUop_d.valid = pop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q        <= '0;
      count_q        <= '0;
      lockout_q      <= '0;
      outUop_q.valid <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      count_q   <= count_d;
      lockout_q <= lockout_d;
      outUop_q  <= outUop_d;
    end
  end

  always_ff @(posedge clk) begin
    entries_q <= entries_d;
  end

  assign bus.OUT_uop  = outUop_q;
  assign bus.OUT_en   = outUop_q.valid;
  assign bus.OUT_full = full;

  a_noEnqWhenFull : assert property (@(posedge clk) disable iff (rst)
    !(bus.IN_uop.valid && full && !inSquashed));

endmodule

// File: tb/tb_div_issue_queue.sv
// Randomized and directed checking of div_issue_queue against a queue-based
// behavioural model of squash / pop / append.
module tb_div_issue_queue;
  import div_issue_queue_pkg::*;

  localparam int DEPTH = 4;

  logic clk;
  logic rst;

  div_issue_queue_if bus ();

  div_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int    testsRun  = 0;
  int    failCount = 0;
  bit    modelReady = 0;
  EX_UOp modelQ[$];
  EX_UOp keptQ[$];
  EX_UOp modelOut;
  int    modelLock;
  bit    wasFull;
  bit    headLives;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic bit youngerThan(input SqN x, input SqN b);
    int d;
    d = (int'(x) - int'(b)) & ((1 << SQN_W) - 1);
    return (d >= 1) && (d < (1 << (SQN_W - 1)));
  endfunction

  function automatic bit killed(input SqN x, input BranchProv br);
    return br.taken && youngerThan(x, br.sqN);
  endfunction

  // Reference model: drop squashed uops, pop the surviving head, append the newcomer.
  always @(posedge clk) begin
    if (rst) begin
      modelQ.delete();
      modelOut.valid = 1'b0;
      modelLock = 0;
    end else begin
      wasFull   = (modelQ.size() == DEPTH);
      headLives = (modelQ.size() > 0) && !killed(modelQ[0].sqN, bus.IN_branch);
      keptQ.delete();
      foreach (modelQ[i]) begin
        if (!killed(modelQ[i].sqN, bus.IN_branch)) keptQ.push_back(modelQ[i]);
      end
      modelQ = keptQ;
      if (headLives && !bus.IN_divBusy && modelLock == 0) begin
        modelOut = modelQ.pop_front();
        modelOut.valid = 1'b1;
        modelLock = 1;
      end else begin
        modelOut.valid = 1'b0;
        modelLock = 0;
      end
      if (bus.IN_uop.valid && !wasFull && !killed(bus.IN_uop.sqN, bus.IN_branch))
        modelQ.push_back(bus.IN_uop);
    end
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    testsRun++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (modelReady) begin
      checkOutput("model_en", bus.OUT_en, modelOut.valid);
      checkOutput("model_valid", bus.OUT_uop.valid, modelOut.valid);
      checkOutput("model_full", bus.OUT_full, modelQ.size() == DEPTH);
      checkOutput("model_count", dut.count_q, modelQ.size());
      if (modelOut.valid) begin
        checkOutput("model_sqN", bus.OUT_uop.sqN, modelOut.sqN);
        checkOutput("model_srcA", bus.OUT_uop.srcA, modelOut.srcA);
        checkOutput("model_srcB", bus.OUT_uop.srcB, modelOut.srcB);
        checkOutput("model_opcode", bus.OUT_uop.opcode, modelOut.opcode);
        checkOutput("model_tag", bus.OUT_uop.tagDst, modelOut.tagDst);
      end
    end
  end

  // Called at a negedge; drives inputs for the coming edge and returns at the next negedge.
  task automatic applyStimulus(input bit v, input SqN sq, input logic [31:0] a,
                               input logic [31:0] b, input DivOp op, input bit br,
                               input SqN brSq, input bit busy);
    bus.IN_uop     = '{srcA: a, srcB: b, sqN: sq, tagDst: Tag'(sq), opcode: op, valid: v};
    bus.IN_branch  = '{sqN: brSq, taken: br};
    bus.IN_divBusy = busy;
    @(negedge clk);
  endtask

  task automatic idleCycle(input bit busy);
    applyStimulus(1'b0, '0, 32'd0, 32'd0, DIV_DIV, 1'b0, '0, busy);
  endtask

  task automatic enqueue(input SqN sq, input bit busy);
    applyStimulus(1'b1, sq, 32'd1000 + 32'(sq), 32'd3, DIV_DIVU, 1'b0, '0, busy);
  endtask

  initial begin
    SqN          seen[$];
    int          seenAt[$];
    SqN          nextSq;
    bit          v;
    bit          br;
    logic [31:0] a;
    logic [31:0] b;

    rst            = 1'b1;
    bus.IN_uop     = '0;
    bus.IN_branch  = '0;
    bus.IN_divBusy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_valid", bus.OUT_uop.valid, 0);
    checkOutput("reset_en", bus.OUT_en, 0);
    checkOutput("reset_full", bus.OUT_full, 0);
    checkOutput("reset_count", dut.count_q, 0);
    rst = 1'b0;
    modelReady = 1'b1;

    // Single DIVU 100/7 into an empty queue with idle divider.
    applyStimulus(1'b1, SqN'(1), 32'd100, 32'd7, DIV_DIVU, 1'b0, '0, 1'b0);
    checkOutput("single_not_yet", bus.OUT_uop.valid, 0);
    checkOutput("single_count", dut.count_q, 1);
    idleCycle(1'b0);
    checkOutput("single_issue", bus.OUT_uop.valid, 1);
    checkOutput("single_sqN", bus.OUT_uop.sqN, 1);
    checkOutput("single_quotient", bus.OUT_uop.srcA / bus.OUT_uop.srcB, 14);
    idleCycle(1'b0);
    checkOutput("single_pulse", bus.OUT_uop.valid, 0);

    // Three back-to-back while the divider is busy, then drain.
    enqueue(SqN'(5), 1'b1);
    enqueue(SqN'(6), 1'b1);
    enqueue(SqN'(7), 1'b1);
    checkOutput("b2b_count", dut.count_q, 3);
    checkOutput("b2b_full", bus.OUT_full, 0);
    for (int k = 0; k < 10; k++) begin
      idleCycle(1'b0);
      if (bus.OUT_uop.valid) begin
        seen.push_back(bus.OUT_uop.sqN);
        seenAt.push_back(k);
      end
    end
    checkOutput("b2b_issued", seen.size(), 3);
    if (seen.size() == 3) begin
      checkOutput("b2b_first", seen[0], 5);
      checkOutput("b2b_second", seen[1], 6);
      checkOutput("b2b_third", seen[2], 7);
      checkOutput("b2b_gap1", seenAt[1] - seenAt[0], 2);
      checkOutput("b2b_gap2", seenAt[2] - seenAt[1], 2);
    end

    // Fill to DEPTH, then reset with a branch pending.
    enqueue(SqN'(21), 1'b1);
    enqueue(SqN'(22), 1'b1);
    enqueue(SqN'(23), 1'b1);
    checkOutput("fill_not_full", bus.OUT_full, 0);
    enqueue(SqN'(24), 1'b1);
    checkOutput("fill_full", bus.OUT_full, 1);
    checkOutput("fill_count", dut.count_q, 4);
    rst = 1'b1;
    applyStimulus(1'b0, '0, 32'd0, 32'd0, DIV_DIV, 1'b1, SqN'(21), 1'b1);
    rst = 1'b0;
    checkOutput("midrst_count", dut.count_q, 0);
    checkOutput("midrst_full", bus.OUT_full, 0);
    checkOutput("midrst_valid", bus.OUT_uop.valid, 0);

    // Flush: 10,12,14,16 then taken branch at 12.
    enqueue(SqN'(10), 1'b1);
    enqueue(SqN'(12), 1'b1);
    enqueue(SqN'(14), 1'b1);
    enqueue(SqN'(16), 1'b1);
    applyStimulus(1'b0, '0, 32'd0, 32'd0, DIV_DIV, 1'b1, SqN'(12), 1'b1);
    checkOutput("flush_count", dut.count_q, 2);
    checkOutput("flush_full", bus.OUT_full, 0);
    idleCycle(1'b0);
    checkOutput("flush_issue", bus.OUT_uop.valid, 1);
    checkOutput("flush_sqN", bus.OUT_uop.sqN, 10);
    idleCycle(1'b0);
    idleCycle(1'b0);
    checkOutput("flush_next_sqN", bus.OUT_uop.sqN, 12);
    idleCycle(1'b0);
    checkOutput("flush_drained", dut.count_q, 0);

    // Squash of the uop sitting on the divider port.
    enqueue(SqN'(20), 1'b0);
    idleCycle(1'b0);
    checkOutput("inflight_valid", bus.OUT_uop.valid, 1);
    checkOutput("inflight_sqN", bus.OUT_uop.sqN, 20);
    applyStimulus(1'b0, '0, 32'd0, 32'd0, DIV_DIV, 1'b1, SqN'(18), 1'b0);
    checkOutput("inflight_killed", bus.OUT_uop.valid, 0);
    checkOutput("inflight_en", bus.OUT_en, 0);

    // Pop, squash and enqueue in one cycle.
    enqueue(SqN'(3), 1'b1);
    enqueue(SqN'(4), 1'b1);
    enqueue(SqN'(9), 1'b1);
    applyStimulus(1'b1, SqN'(11), 32'd50, 32'd5, DIV_DIV, 1'b1, SqN'(8), 1'b0);
    checkOutput("simul_valid", bus.OUT_uop.valid, 1);
    checkOutput("simul_sqN", bus.OUT_uop.sqN, 3);
    checkOutput("simul_count", dut.count_q, 1);
    idleCycle(1'b0);
    checkOutput("simul_lockout", bus.OUT_uop.valid, 0);
    idleCycle(1'b0);
    checkOutput("simul_next_sqN", bus.OUT_uop.sqN, 4);
    checkOutput("simul_empty", dut.count_q, 0);

    // Randomized traffic; upstream respects OUT_full.
    nextSq = SqN'(40);
    for (int c = 0; c < 3000; c++) begin
      v  = !bus.OUT_full && ($urandom_range(0, 1) == 1);
      br = ($urandom_range(0, 9) == 0);
      a  = $urandom;
      b  = $urandom_range(1, 1000);
      rst = ($urandom_range(0, 299) == 0);
      applyStimulus(v, nextSq, a, b, DivOp'($urandom_range(0, 3)), br,
                    nextSq - SqN'($urandom_range(1, 6)), ($urandom_range(0, 9) < 4));
      if (v) nextSq = nextSq + SqN'(1);
    end
    rst = 1'b0;
    idleCycle(1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/div_issue_queue.md
# div_issue_queue

Collapsing, age-ordered holding queue in front of the iterative divider. It accepts divide/remainder uops from the integer issue stage, holds them while the divider is busy, and issues the oldest surviving entry to the divider with the required interlock. It squashes mispredicted-path entries on branch flush, so upstream never has to stall on divider occupancy until the queue itself is full.

## Interface
- `DEPTH`, 4: number of queue entries (≥2).
- `clk`  in  1: clock.
- `rst`  in  1: synchronous, active-high reset.
- `IN_branch`  in  BranchProv: branch resolution; `taken` and `sqN` are used.
- `IN_uop`  in  EX_UOp: enqueue candidate; `valid` qualifies it.
- `OUT_full`  out  1: no free entry; upstream must not present a valid uop.
- `IN_divBusy`  in  1: divider `OUT_busy`.
- `OUT_en`  out  1: divider enable, asserted whenever `OUT_uop.valid`.
- `OUT_uop`  out  EX_UOp: uop presented to the divider, registered.

## Operation
- **Storage:** `DEPTH` entries of EX_UOp plus a valid bit, compacted toward index 0. Index 0 is the oldest surviving entry. `count` is the number of valid entries.
- **Enqueue:** when `IN_uop.valid`, `!OUT_full`, and `IN_uop` is not squashed by `IN_branch`, write the uop at the first free index after compaction and issue for this cycle.
- **Squash predicate:** `IN_branch.taken && $signed(x.sqN - IN_branch.sqN) > 0`. It applies to every stored entry, to the incoming uop, and to a valid `OUT_uop`. Squashed entries are invalidated and the queue compacts in the same cycle. A squashed `OUT_uop` has `valid` cleared at the next edge.
- **Issue condition at an edge:** entry 0 is valid and not squashed, `!IN_divBusy`, and `lockout == 0`.
  - On issue: `OUT_uop <= entry0`, `OUT_uop.valid <= 1`, remaining entries shift down by one, `lockout <= 1`.
  - Otherwise `OUT_uop.valid <= 0`.
- **Lockout:** one cycle. The divider raises busy only one cycle after it accepts, so the edge directly after an issue must not issue again. `lockout` decrements to 0 each cycle.
- **Simultaneous events:** issue, enqueue and squash can occur in one cycle. The order is squash, then issue (pop), then enqueue into the compacted tail.
- **Full:** `OUT_full = (count == DEPTH)`, computed from registered state. An enqueue while full and not popping is not accepted. Simulation asserts it never happens.
- **Full with pop:** an enqueue in the same cycle as a pop while `OUT_full` is still refused, so upstream sees a conservative full.
- **Age ordering:** uops arrive in issue order. The queue preserves arrival order and never reorders by sqN.

## Timing
- **Reset:** all entry valids 0, `count` 0, `lockout` 0, `OUT_uop.valid` 0, `OUT_en` 0, `OUT_full` 0. `OUT_uop` payload is don't-care.
- **Latency:** with an empty queue and an idle divider, an enqueue at edge E makes the entry visible. Issue happens at edge E+1 and the divider captures at E+2, for 2 cycles enqueue-to-capture.
- **Back-to-back issue:** minimum spacing is 2 edges, and further limited by `IN_divBusy`.
- **Reset mid-operation:** the queue is empty and `OUT_uop.valid` is 0 after the reset edge, regardless of pending entries or branch.
- **Flush:** a flush in cycle C takes effect at the edge ending C. `OUT_full` reflects the compacted count from the next cycle.

## Structure
- EX_UOp, BranchProv and the DIV_* opcodes come from the shared package. No new package types.
- The squash predicate is a shared package function `IsSquashed(sqN, BranchProv)`, reused by the divider.
- The lockout counter width is a local constant.
- No sub-module. Compaction is a generate loop over `DEPTH`.

## Test plan
- **Single issue:** enqueue DIVU 100/7 into an empty queue with the divider idle -> `OUT_uop.valid` high exactly one cycle later. The divider result is 14.
- **Three back-to-back, divider busy:** enqueue sqN 5, 6, 7 while `IN_divBusy` is held high -> `count` is 3 and `OUT_full` is 0. When busy drops, 5, 6, 7 issue in order, each separated by at least 2 cycles plus busy.
- **Fill to `DEPTH` = 4:** `OUT_full` is high from the cycle after the 4th enqueue. A 5th valid uop presented is rejected and fires the assertion.
- **Flush:** queue holds sqN 10, 12, 14, 16, then branch taken with sqN 12 -> 14 and 16 are removed, `count` is 2, and 10 issues next.
- **Squash of in-flight output:** `OUT_uop` has sqN 20 and valid, in the same cycle as branch taken with sqN 18 -> valid is 0 after the edge and the divider produces no result.
- **Simultaneous pop, squash and enqueue:** entries sqN 3, 4, 9 plus incoming 11, branch with sqN 8 -> 3 issues, 9 and 11 are dropped, and the queue holds only 4.
